// File: rtl/text_ram_arbiter.sv
// text_ram_arbiter: shares the single-port text RAM between the renderer line
// fetch (read-only) and the parser edit engine (read/write). One RAM access is
// issued per cycle. Read data is routed back to its owner through a tag shift
// register that matches the RAM read latency. A starvation counter forces an
// edit through after STARVE_LIMIT consecutive lost arbitrations.
module text_ram_arbiter #(
    parameter int LINE_W       = 2560,
    parameter int ADDR_W       = 8,
    parameter int RD_LAT       = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    // renderer line fetch
    input  logic              rnd_req,
    input  logic [ADDR_W-1:0] rnd_addr,
    output logic              rnd_gnt,
    output logic              rnd_rvalid,
    output logic [LINE_W-1:0] rnd_rdata,
    // parser edit engine
    input  logic              ed_req,
    input  logic              ed_wren,
    input  logic [ADDR_W-1:0] ed_addr,
    input  logic [LINE_W-1:0] ed_wdata,
    output logic              ed_gnt,
    output logic              ed_rvalid,
    output logic [LINE_W-1:0] ed_rdata,
    // RAM port
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [LINE_W-1:0] ram_wdata,
    input  logic [LINE_W-1:0] ram_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;
    logic             ed_force;
    logic             rd_issue;

    // Tag pipeline: slot k holds the read issued k+1 edges ago.
    // own_pipe bit is 1 when the read belongs to the edit engine.
    logic [RD_LAT:0]  vld_pipe;
    logic [RD_LAT:0]  own_pipe;

    // Arbitration: renderer has priority unless the edit engine has lost
    // STARVE_LIMIT cycles in a row. Grants are suppressed while in reset so
    // every output reads 0 the moment rst rises.
    always_comb begin
        ed_force = (starve_cnt == CNT_MAX);
        rnd_gnt  = 1'b0;
        ed_gnt   = 1'b0;
        if (!rst) begin
            if (rnd_req && !(ed_req && ed_force))
                rnd_gnt = 1'b1;
            else if (ed_req)
                ed_gnt = 1'b1;
        end
    end

    assign rd_issue = rnd_gnt | (ed_gnt & ~ed_wren);

    // Starvation counter: counts consecutive cycles a pending edit loses,
    // cleared on an edit grant or when the edit engine withdraws.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            starve_cnt <= '0;
        else if (!ed_req || ed_gnt)
            starve_cnt <= '0;
        else if (starve_cnt != CNT_MAX)
            starve_cnt <= starve_cnt + 1'b1;
    end

    // RAM issue register: loads the winner; an idle slot only drops the write
    // enable so address and data hold (renderer never writes).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_addr  <= '0;
            ram_wren  <= 1'b0;
            ram_wdata <= '0;
        end else if (rnd_gnt) begin
            ram_addr  <= rnd_addr;
            ram_wren  <= 1'b0;
        end else if (ed_gnt) begin
            ram_addr  <= ed_addr;
            ram_wren  <= ed_wren;
            ram_wdata <= ed_wdata;
        end else begin
            ram_wren  <= 1'b0;
        end
    end

    // Owner tag shift register: one entry per cycle, writes and idle slots
    // push an invalid tag so returns stay aligned with ram_rdata.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            own_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[RD_LAT-1:0], rd_issue};
            own_pipe <= {own_pipe[RD_LAT-1:0], ed_gnt};
        end
    end

    // Return routing: the oldest tag names the owner of this cycle's ram_rdata.
    assign rnd_rvalid = vld_pipe[RD_LAT] & ~own_pipe[RD_LAT];
    assign ed_rvalid  = vld_pipe[RD_LAT] &  own_pipe[RD_LAT];
    assign rnd_rdata  = rnd_rvalid ? ram_rdata : '0;
    assign ed_rdata   = ed_rvalid  ? ram_rdata : '0;

endmodule

// File: tb/tb_text_ram_arbiter.sv
// Bench for text_ram_arbiter: directed stimulus, a behavioural RAM with
// RD_LAT read latency, and a scoreboard of expected read returns checked by a
// separate monitor branch.
module tb_text_ram_arbiter;

    localparam int LINE_W       = 2560;
    localparam int ADDR_W       = 8;
    localparam int RD_LAT       = 2;
    localparam int STARVE_LIMIT = 4;

    logic              clk, rst;
    logic              rnd_req, rnd_gnt, rnd_rvalid;
    logic [ADDR_W-1:0] rnd_addr;
    logic [LINE_W-1:0] rnd_rdata;
    logic              ed_req, ed_wren, ed_gnt, ed_rvalid;
    logic [ADDR_W-1:0] ed_addr;
    logic [LINE_W-1:0] ed_wdata, ed_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wren;
    logic [LINE_W-1:0] ram_wdata, ram_rdata;

    text_ram_arbiter #(
        .LINE_W(LINE_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .rnd_req(rnd_req), .rnd_addr(rnd_addr), .rnd_gnt(rnd_gnt),
        .rnd_rvalid(rnd_rvalid), .rnd_rdata(rnd_rdata),
        .ed_req(ed_req), .ed_wren(ed_wren), .ed_addr(ed_addr), .ed_wdata(ed_wdata),
        .ed_gnt(ed_gnt), .ed_rvalid(ed_rvalid), .ed_rdata(ed_rdata),
        .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Background row contents before any write.
    function automatic logic [LINE_W-1:0] row_pat(input int r);
        logic [31:0] w;
        w = 32'hC0DE_0000 | 32'(r);
        return {(LINE_W/32){w}};
    endfunction

    // Behavioural single-port RAM, write-through, RD_LAT cycles of read latency.
    logic [LINE_W-1:0] mem     [256];
    bit                written [256];
    logic [LINE_W-1:0] rpipe   [RD_LAT];
    always @(posedge clk) begin
        if (ram_wren) begin
            mem[ram_addr]     <= ram_wdata;
            written[ram_addr] <= 1'b1;
        end
        rpipe[0] <= ram_wren ? ram_wdata :
                    (written[ram_addr] ? mem[ram_addr] : row_pat(int'(ram_addr)));
        for (int k = 1; k < RD_LAT; k++) rpipe[k] <= rpipe[k-1];
    end
    assign ram_rdata = rpipe[RD_LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic              own;   // 1 = edit engine
        logic [LINE_W-1:0] data;
        int                due;
    } ret_t;

    ret_t              sb [$];
    logic [LINE_W-1:0] exp_mem [int];
    int                n_vec = 0;
    int                n_err = 0;
    bit                done  = 1'b0;
    logic              g_r, g_e;
    logic [LINE_W-1:0] aa_word;

    function automatic logic [LINE_W-1:0] exp_row(input logic [ADDR_W-1:0] a);
        if (exp_mem.exists(int'(a))) return exp_mem[int'(a)];
        return row_pat(int'(a));
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Observe one cycle's grants at the falling edge, record expected returns,
    // then step to just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        g_r = rnd_gnt;
        g_e = ed_gnt;
        if (rnd_gnt) sb.push_back('{1'b0, exp_row(rnd_addr), cyc + 1 + RD_LAT});
        if (ed_gnt) begin
            if (ed_wren) exp_mem[int'(ed_addr)] = ed_wdata;
            else         sb.push_back('{1'b1, exp_row(ed_addr), cyc + 1 + RD_LAT});
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        rnd_req = 1'b0; ed_req = 1'b0; ed_wren = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_rnd_gnt"},    rnd_gnt,         0);
        chk({nm, "_ed_gnt"},     ed_gnt,          0);
        chk({nm, "_rnd_rvalid"}, rnd_rvalid,      0);
        chk({nm, "_ed_rvalid"},  ed_rvalid,       0);
        chk({nm, "_ram_wren"},   ram_wren,        0);
        chk({nm, "_ram_addr"},   ram_addr,        0);
        chk({nm, "_ram_wdata"},  ram_wdata[63:0], 0);
    endtask

    initial begin
        aa_word  = {(LINE_W/8){8'hAA}};
        rst      = 1'b1;
        rnd_req  = 1'b1; rnd_addr = 8'd0;
        ed_req   = 1'b1; ed_wren  = 1'b0; ed_addr = 8'd1; ed_wdata = '0;
        fork
            begin : driver
                // Reset held with both requesting: everything quiet.
                repeat (2) @(negedge clk);
                chk_reset_outputs("rst");
                @(posedge clk); #1;
                rst = 1'b0;
                tick();
                chk("first_rnd_gnt", g_r, 1);
                chk("first_ed_gnt",  g_e, 0);
                idle();
                repeat (4) tick();

                // Lone renderer read of row 5.
                rnd_req = 1'b1; rnd_addr = 8'd5;
                tick();
                rnd_req = 1'b0;
                chk("rd5_gnt",      g_r,      1);
                chk("rd5_ram_addr", ram_addr, 5);
                chk("rd5_ram_wren", ram_wren, 0);
                repeat (4) tick();

                // Both requesting continuously: R,R,R,R,E repeating.
                rnd_req = 1'b1; ed_req = 1'b1; ed_wren = 1'b0; ed_addr = 8'd40;
                for (int i = 0; i < 15; i++) begin
                    rnd_addr = 8'(20 + i);
                    tick();
                    chk("starve_rnd_gnt", g_r, (i % 5) != 4);
                    chk("starve_ed_gnt",  g_e, (i % 5) == 4);
                end
                idle();
                repeat (4) tick();

                // Edit write row 3 then read it straight back.
                ed_req = 1'b1; ed_wren = 1'b1; ed_addr = 8'd3; ed_wdata = aa_word;
                tick();
                chk("wr3_gnt",       g_e,             1);
                chk("wr3_ram_wren",  ram_wren,        1);
                chk("wr3_ram_addr",  ram_addr,        3);
                chk("wr3_ram_wdata", ram_wdata[63:0], aa_word[63:0]);
                ed_wren = 1'b0;
                tick();
                chk("rd3_gnt",       g_e,      1);
                chk("rd3_ram_wren",  ram_wren, 0);
                chk("rd3_ram_addr",  ram_addr, 3);
                idle();
                repeat (5) tick();

                // Alternating renderer / edit reads every cycle.
                for (int i = 0; i < 8; i++) begin
                    if (i % 2 == 0) begin
                        rnd_req = 1'b1; rnd_addr = 8'(60 + i); ed_req = 1'b0;
                    end else begin
                        ed_req = 1'b1; ed_wren = 1'b0; ed_addr = 8'(60 + i); rnd_req = 1'b0;
                    end
                    tick();
                    chk("alt_gnt", {g_r, g_e}, (i % 2 == 0) ? 2'b10 : 2'b01);
                end
                idle();
                repeat (5) tick();

                // Reset with reads in flight and a part-built starve count.
                rnd_req = 1'b1; rnd_addr = 8'd7; ed_req = 1'b1; ed_wren = 1'b0; ed_addr = 8'd8;
                repeat (3) tick();
                rst = 1'b1;
                sb.delete();
                repeat (2) @(negedge clk);
                chk_reset_outputs("midrst");
                @(posedge clk); #1;
                rst = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    tick();
                    chk("postrst_rnd_gnt", g_r, i != 4);
                    chk("postrst_ed_gnt",  g_e, i == 4);
                end
                idle();
                repeat (8) tick();
                chk("sb_drained", sb.size(), 0);
                done = 1'b1;
            end
            begin : monitor
                ret_t e;
                while (!done) begin
                    @(negedge clk);
                    if (rnd_rvalid || ed_rvalid) begin
                        chk("rvalid_onehot", rnd_rvalid & ed_rvalid, 0);
                        if (sb.size() == 0) begin
                            chk("unexpected_rvalid", {rnd_rvalid, ed_rvalid}, 0);
                        end else begin
                            e = sb.pop_front();
                            chk("ret_cycle", cyc, e.due);
                            chk("ret_owner", {rnd_rvalid, ed_rvalid}, e.own ? 2'b01 : 2'b10);
                            chk("ret_data",
                                e.own ? ed_rdata[63:0] : rnd_rdata[63:0], e.data[63:0]);
                            chk("ret_data_hi",
                                e.own ? ed_rdata[LINE_W-1 -: 64] : rnd_rdata[LINE_W-1 -: 64],
                                e.data[LINE_W-1 -: 64]);
                        end
                    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                        e = sb.pop_front();
                        chk("missing_return", cyc, 64'hFFFF_FFFF);
                    end
                end
            end
        join
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
